// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM port initiator: default geometry and FSM states.
package sram_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int NUM_WMASKS_DEF = DATA_WIDTH_DEF / 8;

    // INIT zero-fills the macro, RUN serves requests.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO holding {addr, rdata} for completed reads.
// Pointers carry one extra bit so full/empty are unambiguous; the low bits
// index storage and wrap modulo DEPTH. Overflow is prevented upstream by credits.
module sram_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign pop_data = mem[rd_ptr[PW-1:0]];

    // Pointer update; simultaneous push and pop leave occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/sram_port_initiator.sv
// Valid/ready front end for a single-port synchronous SRAM macro.
// Requests accepted at edge k are registered onto the macro pins for one cycle,
// the macro samples them at k+1 and read data is captured at k+2 into a
// response FIFO. A credit counter (FIFO occupancy + reads in flight) keeps
// the FIFO from ever overflowing, so reads never need to be stalled mid-pipe.
module sram_port_initiator
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int NUM_WMASKS    = NUM_WMASKS_DEF,
    parameter int RSP_DEPTH     = 4,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  init_busy
);

    localparam int             CW       = $clog2(RSP_DEPTH) + 1;
    localparam logic [CW-1:0]  CRED_MAX = CW'(RSP_DEPTH);
    localparam state_e         ST_RST   = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

    state_e                         state;
    state_e                         state_nxt;
    logic [ADDR_WIDTH-1:0]          init_cnt;
    logic                           init_last;
    logic [CW-1:0]                  credits;
    logic [2:1]                     vld_pipe;
    logic [2:1][ADDR_WIDTH-1:0]     addr_pipe;
    logic                           accept;
    logic                           rd_acc;
    logic                           pop;
    logic                           fifo_empty;

    assign init_last = (init_cnt == {ADDR_WIDTH{1'b1}});
    assign accept    = req_valid && req_ready;
    assign rd_acc    = accept && !req_we;
    assign rsp_valid = !fifo_empty;
    assign pop       = rsp_valid && rsp_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_RST;
        else
            state <= state_nxt;
    end

    // Next state: leave INIT once the last address has been zero-filled.
    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_last)
            state_nxt = ST_RUN;
    end

    // Outputs: writes are always admissible in RUN, reads only with a free credit.
    always_comb begin
        init_busy = (state == ST_INIT);
        req_ready = 1'b0;
        if (!rst && state == ST_RUN)
            req_ready = req_we || (credits < CRED_MAX);
    end

    // Zero-fill address counter; restarts at 0 on every reset.
    always_ff @(posedge clk) begin
        if (rst)
            init_cnt <= '0;
        else if (state == ST_INIT)
            init_cnt <= init_cnt + ADDR_WIDTH'(1);
    end

    // Macro pins are pure flops: idle unless zero-filling or a request was accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
            wmask0 <= '0;
            addr0  <= '0;
            din0   <= '0;
        end else if (state == ST_INIT) begin
            csb0   <= 1'b0;
            web0   <= 1'b0;
            wmask0 <= '1;
            addr0  <= init_cnt;
            din0   <= '0;
        end else if (accept) begin
            csb0   <= 1'b0;
            web0   <= !req_we;
            wmask0 <= req_we ? req_wmask : '0;
            addr0  <= req_addr;
            din0   <= req_we ? req_wdata : '0;
        end else begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
            wmask0 <= '0;
            addr0  <= '0;
            din0   <= '0;
        end
    end

    // Read tracking: stage 1 = on the pins, stage 2 = dout0 valid this cycle.
    always_ff @(posedge clk) begin
        if (rst)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[1], rd_acc};
        addr_pipe <= {addr_pipe[1], req_addr};
    end

    // Credits cover reads in flight plus FIFO entries; push only moves one between them.
    always_ff @(posedge clk) begin
        if (rst)
            credits <= '0;
        else
            credits <= credits + CW'(rd_acc) - CW'(pop);
    end

    // dout0 is only sampled when a tracked read reaches stage 2.
    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH + ADDR_WIDTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_pipe[2]),
        .push_data ({addr_pipe[2], dout0}),
        .pop       (pop),
        .pop_data  ({rsp_addr, rsp_rdata}),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_sram_port_initiator.sv
// Directed bench for sram_port_initiator with a behavioural SRAM macro.
// Stimulus pushes expected read responses into a queue; an independent
// monitor pops and compares whenever a response handshake occurs.
module tb_sram_port_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [7:0]  rsp_addr;
    logic        csb0, web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0, dout0;
    logic        init_busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [39:0] exp_q [$];

    always #5 clk = ~clk;

    sram_port_initiator dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
        .din0(din0), .dout0(dout0), .init_busy(init_busy)
    );

    // Behavioural macro: samples pins at posedge, read data valid for one cycle.
    logic [31:0] mem [256];
    logic [31:0] dout_r;
    assign dout0 = dout_r;
    always @(posedge clk) begin
        if (!csb0 && !web0)
            for (int b = 0; b < 4; b++)
                if (wmask0[b]) mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
        dout_r <= (!csb0 && web0) ? mem[addr0] : 'x;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each response handshake and check stability under back-pressure.
    initial begin
        logic        hold;
        logic [39:0] held, e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold)
                    chk("rsp_hold", {7'd0, rsp_valid, rsp_addr, rsp_rdata}, {7'd0, 1'b1, held});
                hold = 1'b0;
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", {32'd0, rsp_addr, rsp_rdata}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_addr", {56'd0, rsp_addr}, {56'd0, e[39:32]});
                        chk("rsp_data", {32'd0, rsp_rdata}, {32'd0, e[31:0]});
                    end
                end else if (rsp_valid) begin
                    hold = 1'b1;
                    held = {rsp_addr, rsp_rdata};
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input bit we, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic [31:0] exp);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
        for (int w = 0; w <= 20 && !ok; w++) begin
            #1;
            if (req_ready) ok = 1'b1;
            else if (w == 20) chk("accept_timeout", {63'd0, req_ready}, 64'd1);
            else @(negedge clk);
        end
        if (ok && !we) exp_q.push_back({a, exp});
        if (!ok) req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(negedge clk);
        chk(name, exp_q.size(), 0);
    endtask

    // Reset for two cycles, check idle state, then follow the zero-fill sweep.
    task automatic reset_and_sweep(input string tag);
        int busy, sweep, serr;
        bit done;
        busy = 0; sweep = 0; serr = 0; done = 1'b0;
        rst = 1'b1; req_valid = 1'b0; exp_q.delete();
        @(negedge clk);
        #1;
        chk({tag, "_rst_csb0"}, {63'd0, csb0}, 64'd1);
        chk({tag, "_rst_pins"}, {web0, wmask0, addr0, din0}, {1'b1, 4'h0, 8'h00, 32'h0});
        chk({tag, "_rst_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        chk({tag, "_rst_req_ready"}, {63'd0, req_ready}, 64'd0);
        chk({tag, "_rst_init_busy"}, {63'd0, init_busy}, 64'd1);
        @(negedge clk);
        rst = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            #1;
            if (init_busy) busy++;
            if (!csb0 && !web0) begin
                if (addr0 !== sweep[7:0] || wmask0 !== 4'hF || din0 !== 32'h0) serr++;
                sweep++;
            end
            if (!init_busy && csb0) done = 1'b1;
            else @(negedge clk);
        end
        chk({tag, "_init_busy_cycles"}, busy, 256);
        chk({tag, "_sweep_len"}, sweep, 256);
        chk({tag, "_sweep_order"}, serr, 0);
        @(negedge clk);
    endtask

    initial begin
        int acc;
        logic last_ready;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;
        @(negedge clk);

        // Power-on reset and full zero-fill, then a read of filled memory.
        reset_and_sweep("por");
        send(1'b0, 8'h37, '0, '0, 32'h0000_0000);
        idle(4);

        // Byte-masked overwrite and read latency.
        send(1'b1, 8'h10, 32'hDEAD_BEEF, 4'b1111, '0);
        send(1'b1, 8'h10, 32'h0000_00AA, 4'b0001, '0);
        send(1'b0, 8'h10, '0, '0, 32'hDEAD_BEAA);
        req_valid = 1'b0;
        #1 chk("lat_k0", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk); #1 chk("lat_k1", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk); #1 chk("lat_k2", {63'd0, rsp_valid}, 64'd1);
        @(negedge clk);
        idle(3);

        // Credit limit: 6 back-to-back reads with the consumer stalled.
        for (int i = 0; i < 4; i++)
            send(1'b1, 8'h20 + 8'(i), 32'h1111_0020 + 32'(i), 4'hF, '0);
        rsp_ready = 1'b0;
        acc = 0; last_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h20 + 8'(i);
            #1;
            last_ready = req_ready;
            if (req_ready) begin
                acc++;
                exp_q.push_back({8'h20 + 8'(i), 32'h1111_0020 + 32'(i)});
            end
            @(negedge clk);
        end
        chk("stall_accepted", acc, 4);
        chk("stall_ready_low", {63'd0, last_ready}, 64'd0);
        req_we = 1'b1; req_addr = 8'h30; req_wdata = 32'h3030_3030; req_wmask = 4'hF;
        #1 chk("stall_write_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        idle(4);
        rsp_ready = 1'b1;
        wait_drain("stall_drain");
        idle(2);

        // Write immediately followed by read of the same address.
        for (int i = 0; i < 10; i++) begin
            send(1'b1, 8'h05, 32'hA500_0000 + 32'(i), 4'hF, '0);
            send(1'b0, 8'h05, '0, '0, 32'hA500_0000 + 32'(i));
        end
        idle(1);
        wait_drain("alt_drain");
        send(1'b0, 8'h30, '0, '0, 32'h3030_3030);
        idle(1);
        wait_drain("stall_write_data");

        // Reset with reads outstanding: nothing may emerge, fill restarts at 0.
        rsp_ready = 1'b0;
        send(1'b0, 8'h10, '0, '0, 32'hDEAD_BEAA);
        send(1'b0, 8'h05, '0, '0, 32'hA500_0009);
        send(1'b0, 8'h30, '0, '0, 32'h3030_3030);
        reset_and_sweep("mid");
        idle(2);
        send(1'b0, 8'h10, '0, '0, 32'h0000_0000);
        idle(1);
        wait_drain("post_reset_read");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_port_initiator.md
SRAM_PORT_INITIATOR -- requirements
Module: sram_port_initiator

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, SRAM word width; ADDR_WIDTH, default 8, SRAM address width; NUM_WMASKS, default 4, byte-lane write-mask width (DATA_WIDTH/8); RSP_DEPTH, default 4, response FIFO entries (power of 2); INIT_ON_RESET, default 1, zero-fill the macro after reset.
REQ-002 SHALL have ports, clock and reset first: clk in 1, single clock, also drives the macro clk0; rst in 1, synchronous active-high reset.
REQ-003 SHALL have request ports: req_valid in 1, request present; req_ready out 1, request accepted when both high at posedge; req_we in 1, 1=write 0=read; req_addr in ADDR_WIDTH, word address; req_wdata in DATA_WIDTH, write data; req_wmask in NUM_WMASKS, byte enables.
REQ-004 SHALL have response ports: rsp_valid out 1, read data present; rsp_ready in 1, consumer accepts; rsp_rdata out DATA_WIDTH, read data; rsp_addr out ADDR_WIDTH, address of that read.
REQ-005 SHALL have macro-side ports: csb0 out 1, active-low select; web0 out 1, active-low write; wmask0 out NUM_WMASKS; addr0 out ADDR_WIDTH; din0 out DATA_WIDTH; dout0 in DATA_WIDTH; init_busy out 1, zero-fill in progress.

Function
REQ-006 SHALL drive all macro-side outputs from flops only; idle value csb0=1, web0=1, wmask0=0, addr0=0, din0=0.
REQ-007 SHALL accept a request at posedge k and present it on the macro pins during cycle k..k+1, the macro capturing it at posedge k+1.
REQ-008 SHALL write by driving csb0=0, web0=0, wmask0=req_wmask, din0=req_wdata; writes produce no response.
REQ-009 SHALL read by driving csb0=0, web0=1; dout0 is captured at posedge k+2 and pushed into the response FIFO with its address, so rsp_valid is high no earlier than cycle k+2.
REQ-010 SHALL ignore dout0 in every cycle not matched to an issued read (dout0 is X outside the valid window).
REQ-011 SHALL track outstanding reads with a credit counter = FIFO occupancy + reads in flight (pipeline depth 2); a read is accepted only if credits < RSP_DEPTH, a write whenever the FSM is in RUN.
REQ-012 SHALL sustain one request per cycle, mixed reads and writes, in issue order; responses return in request order.
REQ-013 SHALL, when a FIFO push and a pop occur in the same cycle, keep occupancy unchanged; pointers wrap modulo RSP_DEPTH.
REQ-014 SHALL keep rsp_valid/rsp_rdata/rsp_addr stable while rsp_valid=1 and rsp_ready=0.
REQ-015 SHALL implement FSM states INIT, RUN: after reset go to INIT if INIT_ON_RESET=1, else RUN.
REQ-016 SHALL in INIT write zero to addresses 0..2^ADDR_WIDTH-1, one per cycle, wmask0 all ones, counter wrapping at last address into RUN; init_busy=1 and req_ready=0 throughout INIT.
REQ-017 SHALL treat a write followed immediately by a read to the same address as legal; the read returns the new data.

Reset
REQ-018 SHALL on rst: FSM to INIT or RUN per REQ-015; FIFO emptied, credits 0, in-flight reads discarded; macro pins to idle values; rsp_valid=0; req_ready=0 during the reset cycle; init_busy=INIT_ON_RESET.
REQ-019 SHALL on rst asserted mid-INIT or mid-traffic abort all work; the zero-fill restarts at address 0.

Structure
REQ-020 SHALL place DATA_WIDTH/ADDR_WIDTH/NUM_WMASKS defaults and the FSM state enum in shared package sram_ctrl_pkg.
REQ-021 SHALL instantiate one sub-module, sram_rsp_fifo (synchronous FIFO, depth RSP_DEPTH, width DATA_WIDTH+ADDR_WIDTH).

Verification
REQ-022 Reset with INIT_ON_RESET=1 -> init_busy high exactly 256 cycles, addr0 sweeps 0x00..0xFF, then read 0x37 returns 0x00000000.
REQ-023 Write 0xDEADBEEF to 0x10 mask 4'b1111, then write 0x000000AA mask 4'b0001 -> read 0x10 returns 0xDEADBEAA, rsp_valid 2 cycles after accept.
REQ-024 rsp_ready=0, issue 6 back-to-back reads -> exactly 4 accepted, req_ready low after, no data lost when rsp_ready rises.
REQ-025 Alternating write/read to 0x05 every cycle for 20 cycles -> each read returns the immediately preceding write.
REQ-026 Assert rst with 3 reads in flight -> no rsp_valid after reset, csb0=1 next cycle, zero-fill restarts at 0x00.
